// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the FIFO write-side arbiter.
package fifo_write_arbiter_pkg;

    localparam int unsigned BIT_WIDTH      = 32;
    localparam int unsigned WRITE_SIZE_DEF = 2;
    localparam int unsigned MAX_REQ        = 16;
    localparam int unsigned PICK_W         = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    typedef logic [BIT_WIDTH-1:0]        word_t;
    typedef word_t [WRITE_SIZE_DEF-1:0] beat_t;

    // First set bit of valid scanning upward from ptr, wrapping modulo num.
    function automatic logic [PICK_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [PICK_W-1:0]  ptr,
        input int unsigned        num
    );
        logic [PICK_W-1:0] pick;
        logic              found;
        int unsigned       j;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < num) begin
                j = 32'(ptr) + k;
                if (j >= num) j = j - num;
                if (!found && valid[PICK_W'(j)]) begin
                    found = 1'b1;
                    pick  = PICK_W'(j);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_pick.sv
// Combinational rotate/priority-encode of a request vector from a round-robin pointer.
module fifo_write_arbiter_pick
    import fifo_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Pick index and any-valid flag from the rotated request vector.
    always_comb begin
        o_any = |i_valid;
        o_idx = IDX_W'(rr_pick(MAX_REQ'(i_valid), PICK_W'(i_ptr), NUM_REQ));
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH      = BIT_WIDTH,
    parameter int unsigned WRITE_SIZE = WRITE_SIZE_DEF,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,
    input  logic [NUM_REQ-1:0]                           req_valid_i,
    input  logic [NUM_REQ-1:0]                           req_last_i,
    input  logic [NUM_REQ-1:0][WRITE_SIZE-1:0][WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]                           req_ready_o,
    output logic                                         fifo_valid_o,
    output logic [WRITE_SIZE-1:0][WIDTH-1:0]             fifo_data_o,
    input  logic                                         fifo_ready_i,
    output logic [NUM_REQ-1:0]                           grant_o,
    output logic                                         busy_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    arb_state_e          r_state,     w_state_nxt;
    logic [IDX_W-1:0]    r_grant_idx, w_grant_idx_nxt;
    logic [NUM_REQ-1:0]  r_grant,     w_grant_nxt;
    logic [IDX_W-1:0]    r_rr_ptr,    w_rr_ptr_nxt;
    logic [CNT_W-1:0]    r_beat_cnt,  w_beat_cnt_nxt;
    logic                r_busy,      w_busy_nxt;

    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_any_valid;
    logic                w_hs;
    logic                w_release;
    logic [IDX_W-1:0]    w_ptr_after;

    fifo_write_arbiter_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_valid (req_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_any   (w_any_valid)
    );

    // State, grant, pointer and beat counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ARB_IDLE;
            r_grant_idx <= '0;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state logic and the granted-port mux onto the FIFO write port.
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_idx_nxt = r_grant_idx;
        w_grant_nxt     = r_grant;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_busy_nxt      = r_busy;
        req_ready_o     = '0;
        fifo_valid_o    = 1'b0;
        fifo_data_o     = req_data_i[r_grant_idx];
        w_hs            = 1'b0;
        w_release       = 1'b0;
        w_ptr_after     = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                               : r_grant_idx + IDX_W'(1);

        unique case (r_state)
            ARB_IDLE: begin
                if (w_any_valid) begin
                    w_state_nxt     = ARB_BURST;
                    w_grant_idx_nxt = w_pick_idx;
                    w_grant_nxt     = NUM_REQ'(1) << w_pick_idx;
                    w_beat_cnt_nxt  = '0;
                    w_busy_nxt      = 1'b1;
                end
            end
            ARB_BURST: begin
                fifo_valid_o             = req_valid_i[r_grant_idx];
                req_ready_o[r_grant_idx] = fifo_ready_i;
                w_hs = req_valid_i[r_grant_idx] & fifo_ready_i;
                if (w_hs) begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    w_release = req_last_i[r_grant_idx] ||
                                (r_beat_cnt == CNT_W'(BURST_LEN - 1));
                end else begin
                    w_release = !req_valid_i[r_grant_idx];
                end
                if (w_release) begin
                    w_state_nxt  = ARB_IDLE;
                    w_grant_nxt  = '0;
                    w_busy_nxt   = 1'b0;
                    w_rr_ptr_nxt = w_ptr_after;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    assign grant_o = r_grant;
    assign busy_o  = r_busy;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: 4-port and 3-port arbiters against a transaction-level model.
module tb_fifo_write_arbiter;

    typedef logic [3:0][1:0][15:0] data_t;

    localparam int BL = 4;

    logic              clk = 1'b0;
    logic              r_rst;
    logic [3:0]        r_valid;
    logic [3:0]        r_last;
    data_t             r_data;
    logic              r_ready;

    logic [3:0]        ready_a, grant_a;
    logic              fifo_valid_a, busy_a;
    logic [1:0][15:0]  fifo_data_a;
    logic [2:0]        ready_b, grant_b;
    logic              fifo_valid_b, busy_b;
    logic [1:0][15:0]  fifo_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    int m_own [2];
    int m_ptr [2];
    int m_cnt [2];
    int nreq  [2];

    logic [31:0] q_a [$];
    logic [3:0]  q_ga [$];
    logic [3:0]  q_gb [$];
    logic [3:0]  prev_ga, prev_gb;
    logic        last_hs;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.WIDTH(16), .WRITE_SIZE(2), .NUM_REQ(4), .BURST_LEN(BL)) u_dut_a (
        .clk_i(clk), .reset_i(r_rst), .req_valid_i(r_valid), .req_last_i(r_last),
        .req_data_i(r_data), .req_ready_o(ready_a), .fifo_valid_o(fifo_valid_a),
        .fifo_data_o(fifo_data_a), .fifo_ready_i(r_ready), .grant_o(grant_a), .busy_o(busy_a)
    );

    fifo_write_arbiter #(.WIDTH(16), .WRITE_SIZE(2), .NUM_REQ(3), .BURST_LEN(BL)) u_dut_b (
        .clk_i(clk), .reset_i(r_rst), .req_valid_i(r_valid[2:0]), .req_last_i(r_last[2:0]),
        .req_data_i(r_data[2:0]), .req_ready_o(ready_b), .fifo_valid_o(fifo_valid_b),
        .fifo_data_o(fifo_data_b), .fifo_ready_i(r_ready), .grant_o(grant_b), .busy_o(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs follow from who owns the port right now.
    task automatic chk_dut(input int d, input logic [3:0] g, input logic b, input logic v,
                           input logic [3:0] r, input logic [31:0] dat);
        int own;
        logic [3:0] eg, er;
        own = m_own[d];
        eg  = (own < 0) ? 4'd0 : (4'd1 << own);
        er  = (own >= 0 && r_ready) ? (4'd1 << own) : 4'd0;
        chk($sformatf("grant%0d", d), 32'(g), 32'(eg));
        chk($sformatf("busy%0d", d), 32'(b), 32'(own >= 0));
        chk($sformatf("fvalid%0d", d), 32'(v), 32'(own >= 0 && r_valid[own]));
        chk($sformatf("ready%0d", d), 32'(r), 32'(er));
        if (own >= 0 && r_valid[own]) chk($sformatf("fdata%0d", d), dat, r_data[own]);
    endtask

    task automatic model_update(input int d);
        int  n;
        bit  hs, found;
        n = nreq[d];
        if (r_rst) begin
            m_own[d] = -1; m_ptr[d] = 0; m_cnt[d] = 0;
        end else if (m_own[d] < 0) begin
            found = 0;
            for (int k = 0; k < n; k++) begin
                if (!found && r_valid[(m_ptr[d] + k) % n]) begin
                    found = 1; m_own[d] = (m_ptr[d] + k) % n; m_cnt[d] = 0;
                end
            end
        end else begin
            hs = r_valid[m_own[d]] && r_ready;
            if (hs) m_cnt[d]++;
            if ((hs && (r_last[m_own[d]] || m_cnt[d] == BL)) || (!hs && !r_valid[m_own[d]])) begin
                m_ptr[d] = (m_own[d] + 1) % n;
                m_own[d] = -1;
            end
        end
    endtask

    // Drive one cycle of inputs, check both DUTs mid-cycle, then advance the model.
    task automatic step(input logic [3:0] v, input logic [3:0] l, input data_t dat,
                        input logic rdy, input logic rst);
        r_valid = v; r_last = l; r_data = dat; r_ready = rdy; r_rst = rst;
        @(negedge clk);
        chk_dut(0, grant_a, busy_a, fifo_valid_a, ready_a, fifo_data_a);
        chk_dut(1, {1'b0, grant_b}, busy_b, fifo_valid_b, {1'b0, ready_b}, fifo_data_b);
        last_hs = fifo_valid_a && r_ready;
        if (last_hs) q_a.push_back(fifo_data_a);
        if (grant_a != 0 && prev_ga == 0) q_ga.push_back(grant_a);
        if (grant_b != 0 && prev_gb == 0) q_gb.push_back({1'b0, grant_b});
        prev_ga = grant_a; prev_gb = {1'b0, grant_b};
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
    endtask

    function automatic data_t rnd_data();
        data_t d;
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        return d;
    endfunction

    function automatic data_t one(input int r, input logic [31:0] w);
        data_t d;
        d = rnd_data();
        d[r] = w;
        return d;
    endfunction

    task automatic do_reset();
        step(4'b0, 4'b0, rnd_data(), 1'b1, 1'b1);
        step(4'b0, 4'b0, rnd_data(), 1'b1, 1'b1);
        q_a.delete(); q_ga.delete(); q_gb.delete();
    endtask

    logic [31:0] wd;
    int          guard;

    initial begin
        nreq[0] = 4; nreq[1] = 3;
        for (int d = 0; d < 2; d++) begin m_own[d] = -1; m_ptr[d] = 0; m_cnt[d] = 0; end
        prev_ga = '0; prev_gb = '0; last_hs = 1'b0;
        r_valid = '0; r_last = '0; r_data = '0; r_ready = 1'b1; r_rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_grant", 32'(grant_a), 32'h0);
        chk("reset_busy", 32'(busy_a), 32'h0);

        // Single requester, three beats with last on the third.
        step(4'b0010, 4'b0, one(1, 32'h11), 1'b1, 1'b0);
        chk("t1_grant", 32'(grant_a), 32'h2);
        step(4'b0010, 4'b0, one(1, 32'h11), 1'b1, 1'b0);
        step(4'b0010, 4'b0, one(1, 32'h22), 1'b1, 1'b0);
        step(4'b0010, 4'b0010, one(1, 32'h33), 1'b1, 1'b0);
        chk("t1_idle", 32'(grant_a), 32'h0);
        chk("t1_count", q_a.size(), 3);
        if (q_a.size() == 3) begin
            chk("t1_w0", q_a[0], 32'h11); chk("t1_w1", q_a[1], 32'h22); chk("t1_w2", q_a[2], 32'h33);
        end
        step(4'b1011, 4'b0, rnd_data(), 1'b1, 1'b0);
        chk("t1_ptr2_pick3", 32'(grant_a), 32'h8);
        step(4'b0, 4'b0, rnd_data(), 1'b1, 1'b0);

        // All four valid continuously: full bursts in rotation order.
        do_reset();
        for (int i = 0; i < 25; i++) step(4'b1111, 4'b0, rnd_data(), 1'b1, 1'b0);
        step(4'b0, 4'b0, rnd_data(), 1'b1, 1'b0);
        chk("t2_words", q_a.size(), 20);
        chk("t2_bursts", q_ga.size(), 5);
        if (q_ga.size() == 5) begin
            chk("t2_g0", 32'(q_ga[0]), 32'h1); chk("t2_g1", 32'(q_ga[1]), 32'h2);
            chk("t2_g2", 32'(q_ga[2]), 32'h4); chk("t2_g3", 32'(q_ga[3]), 32'h8);
            chk("t2_g4", 32'(q_ga[4]), 32'h1);
        end

        // Backpressure mid-burst on req2.
        do_reset();
        wd = 32'h200;
        step(4'b0100, 4'b0, one(2, wd), 1'b1, 1'b0);
        step(4'b0100, 4'b0, one(2, wd), 1'b1, 1'b0);
        if (last_hs) wd++;
        for (int i = 0; i < 5; i++) begin
            step(4'b0100, 4'b0, one(2, wd), 1'b0, 1'b0);
            chk("t3_hold", 32'(grant_a), 32'h4);
            chk("t3_ready", 32'(ready_a), 32'h0);
        end
        guard = 0;
        while (q_a.size() < 4 && guard < 10) begin
            step(4'b0100, 4'b0, one(2, wd), 1'b1, 1'b0);
            if (last_hs) wd++;
            guard++;
        end
        chk("t3_guard", 32'(guard < 10), 32'h1);
        chk("t3_released", 32'(grant_a), 32'h0);
        step(4'b0, 4'b0, rnd_data(), 1'b1, 1'b0);
        chk("t3_count", q_a.size(), 4);
        for (int i = 0; i < 4 && i < q_a.size(); i++) chk("t3_word", q_a[i], 32'h200 + 32'(i));

        // Requester drop after two beats, req3 waiting.
        do_reset();
        step(4'b1001, 4'b0, one(0, 32'hA0), 1'b1, 1'b0);
        step(4'b1001, 4'b0, one(0, 32'hA0), 1'b1, 1'b0);
        step(4'b1001, 4'b0, one(0, 32'hA1), 1'b1, 1'b0);
        step(4'b1000, 4'b0, rnd_data(), 1'b1, 1'b0);
        chk("t4_release", 32'(grant_a), 32'h0);
        step(4'b1000, 4'b0, rnd_data(), 1'b1, 1'b0);
        chk("t4_grant3", 32'(grant_a), 32'h8);
        step(4'b1000, 4'b1000, one(3, 32'hD0), 1'b1, 1'b0);
        step(4'b0, 4'b0, rnd_data(), 1'b1, 1'b0);
        chk("t4_count", q_a.size(), 3);
        if (q_a.size() == 3) begin
            chk("t4_w0", q_a[0], 32'hA0); chk("t4_w1", q_a[1], 32'hA1); chk("t4_w2", q_a[2], 32'hD0);
        end

        // Reset during the second beat of req1.
        do_reset();
        step(4'b0010, 4'b0, rnd_data(), 1'b1, 1'b0);
        step(4'b0010, 4'b0, rnd_data(), 1'b1, 1'b0);
        step(4'b0010, 4'b0, rnd_data(), 1'b1, 1'b1);
        chk("t5_grant", 32'(grant_a), 32'h0);
        chk("t5_busy", 32'(busy_a), 32'h0);
        chk("t5_fvalid", 32'(fifo_valid_a), 32'h0);
        step(4'b0011, 4'b0, rnd_data(), 1'b1, 1'b0);
        chk("t5_req0_first", 32'(grant_a), 32'h1);
        step(4'b0, 4'b0, rnd_data(), 1'b1, 1'b0);
        step(4'b0, 4'b0, rnd_data(), 1'b1, 1'b0);

        // Requests on 0 and 2 only: the 3-port build must alternate and wrap.
        do_reset();
        for (int i = 0; i < 10; i++) step(4'b0101, 4'b0101, rnd_data(), 1'b1, 1'b0);
        chk("t6_bursts", q_gb.size(), 5);
        if (q_gb.size() >= 4) begin
            chk("t6_g0", 32'(q_gb[0]), 32'h1); chk("t6_g1", 32'(q_gb[1]), 32'h4);
            chk("t6_g2", 32'(q_gb[2]), 32'h1); chk("t6_g3", 32'(q_gb[3]), 32'h4);
        end

        // Random traffic with occasional reset, checked cycle by cycle.
        for (int i = 0; i < 800; i++) begin
            step(4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : 0),
                 rnd_data(),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
